// File: rtl/brqrv_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : brqrv_loader_pkg
// Description : Register map, bit indices, FSM encoding and default address
//               window for the BrqRV Wishbone loader.
// Revision    : 1.0 - initial release
// ============================================================================
package brqrv_loader_pkg;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'h3000_0000;
    localparam logic [31:0] DEF_MEM_OFFSET = 32'h0001_0000;

    localparam logic [3:0] REG_CTRL    = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_WCOUNT  = 4'h8;
    localparam logic [3:0] REG_SCRATCH = 4'hC;

    localparam int CTRL_HOLD    = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int STAT_RUNNING = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_VIOL    = 2;
    localparam int STAT_BAD     = 3;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_MEM_RD  = 2'd1;
    localparam state_t c_ST_MEM_CAP = 2'd2;
    localparam state_t c_ST_ACK     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/brqrv_wb_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : brqrv_wb_loader_if
// Description : Wishbone slave pins plus core memory port of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface brqrv_wb_loader_if #(
    parameter int MEM_AW = 10
);
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [3:0]        mem_wmask_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output mem_en_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  mem_en_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/brqrv_loader_regs.sv
`default_nettype none
// ============================================================================
// Module      : brqrv_loader_regs
// Description : CTRL/STATUS/WCOUNT/SCRATCH storage, core reset and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module brqrv_loader_regs
    import brqrv_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_wr_en,
    input  wire logic [3:0]  i_off,
    input  wire logic [31:0] i_wdata,
    input  wire logic [3:0]  i_sel,
    output logic      [31:0] o_rdata,
    input  wire logic        i_set_viol,
    input  wire logic        i_set_bad,
    input  wire logic        i_wcount_inc,
    input  wire logic        i_core_done,
    output logic             o_hold,
    output logic             o_core_rst,
    output logic             o_irq
);
    logic        r_hold, r_irq_en, r_done, r_viol, r_bad;
    logic        r_core_rst, r_irq;
    logic [15:0] r_wcount;
    logic [31:0] r_scratch;

    logic w_wr_ctrl, w_w1c, w_wr_wcnt, w_wr_scr;
    assign w_wr_ctrl = i_wr_en && (i_off == REG_CTRL) && i_sel[0];
    assign w_w1c     = i_wr_en && (i_off == REG_STATUS) && i_sel[0];
    assign w_wr_wcnt = i_wr_en && (i_off == REG_WCOUNT);
    assign w_wr_scr  = i_wr_en && (i_off == REG_SCRATCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold     <= 1'b1;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_viol     <= 1'b0;
            r_bad      <= 1'b0;
            r_wcount   <= 16'h0000;
            r_scratch  <= 32'h0000_0000;
            r_core_rst <= 1'b1;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_hold   <= i_wdata[CTRL_HOLD];
                r_irq_en <= i_wdata[CTRL_IRQ_EN];
            end
            // Sticky sets take priority over a coincident write-one-to-clear.
            r_done <= i_core_done | (r_done & ~(w_w1c & i_wdata[STAT_DONE]));
            r_viol <= i_set_viol  | (r_viol & ~(w_w1c & i_wdata[STAT_VIOL]));
            r_bad  <= i_set_bad   | (r_bad  & ~(w_w1c & i_wdata[STAT_BAD]));
            if (w_wr_wcnt)
                r_wcount <= 16'h0000;
            else if (i_wcount_inc && (r_wcount != 16'hFFFF))
                r_wcount <= r_wcount + 16'd1;
            for (int b = 0; b < 4; b++) begin
                if (w_wr_scr && i_sel[b])
                    r_scratch[8*b +: 8] <= i_wdata[8*b +: 8];
            end
            r_core_rst <= r_hold;
            r_irq      <= r_done & r_irq_en;
        end
    end

    always_comb begin
        o_rdata = 32'h0000_0000;
        case (i_off)
            REG_CTRL: begin
                o_rdata[CTRL_HOLD]   = r_hold;
                o_rdata[CTRL_IRQ_EN] = r_irq_en;
            end
            REG_STATUS: begin
                o_rdata[STAT_RUNNING] = ~r_hold;
                o_rdata[STAT_DONE]    = r_done;
                o_rdata[STAT_VIOL]    = r_viol;
                o_rdata[STAT_BAD]     = r_bad;
            end
            REG_WCOUNT:  o_rdata[15:0] = r_wcount;
            REG_SCRATCH: o_rdata       = r_scratch;
            default:     o_rdata       = 32'h0000_0000;
        endcase
    end

    assign o_hold     = r_hold;
    assign o_core_rst = r_core_rst;
    assign o_irq      = r_irq;
endmodule
`default_nettype wire

// File: rtl/brqrv_wb_loader.sv
`default_nettype none
// ============================================================================
// Module      : brqrv_wb_loader
// Description : Wishbone classic slave that loads core memory and controls
//               core reset; decode, access FSM and memory port live here.
// Revision    : 1.0 - initial release
// ============================================================================
module brqrv_wb_loader
    import brqrv_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter logic [31:0] MEM_OFFSET = DEF_MEM_OFFSET,
    parameter int          MEM_AW     = 10
) (
    input  wire logic               wb_clk_i,
    input  wire logic               wb_rst_i,
    brqrv_wb_loader_if.slave        bus,
    input  wire logic               core_done_i,
    output logic                    core_rst_o,
    output logic                    irq_o
);
    localparam logic [31:0] c_MEM_BYTES = 32'd4 << MEM_AW;

    state_t            r_state;
    logic              r_ack, r_mem_en, r_mem_we, r_abort;
    logic [31:0]       r_dat, r_wdata;
    logic [3:0]        r_wmask;
    logic [MEM_AW-1:0] r_addr;

    logic        w_req, w_in_mem, w_in_reg, w_hold, w_idle_req;
    logic [31:0] w_off, w_reg_rdata;

    assign w_req      = bus.wbs_cyc_i && bus.wbs_stb_i &&
                        (bus.wbs_adr_i[31:24] == BASE_ADDR[31:24]);
    assign w_off      = bus.wbs_adr_i - BASE_ADDR;
    assign w_in_mem   = (w_off >= MEM_OFFSET) && (w_off < (MEM_OFFSET + c_MEM_BYTES));
    assign w_in_reg   = !w_in_mem && (w_off < 32'd16);
    assign w_idle_req = (r_state == c_ST_IDLE) && w_req;

    brqrv_loader_regs u_regs (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .i_wr_en      (w_idle_req && w_in_reg && bus.wbs_we_i),
        .i_off        ({w_off[3:2], 2'b00}),
        .i_wdata      (bus.wbs_dat_i),
        .i_sel        (bus.wbs_sel_i),
        .o_rdata      (w_reg_rdata),
        .i_set_viol   (w_idle_req && w_in_mem && !w_hold),
        .i_set_bad    (w_idle_req && !w_in_mem && !w_in_reg),
        .i_wcount_inc (w_idle_req && w_in_mem && w_hold && bus.wbs_we_i),
        .i_core_done  (core_done_i),
        .o_hold       (w_hold),
        .o_core_rst   (core_rst_o),
        .o_irq        (irq_o)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= c_ST_IDLE;
            r_ack    <= 1'b0;
            r_dat    <= 32'h0000_0000;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_wmask  <= 4'h0;
            r_addr   <= '0;
            r_wdata  <= 32'h0000_0000;
            r_abort  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        if (w_in_mem && w_hold) begin
                            r_mem_en <= 1'b1;
                            r_mem_we <= bus.wbs_we_i;
                            r_wmask  <= bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
                            r_addr   <= bus.wbs_adr_i[MEM_AW+1:2];
                            r_wdata  <= bus.wbs_dat_i;
                            r_abort  <= 1'b0;
                            // Writes complete in one cycle; reads need the memory latency.
                            if (bus.wbs_we_i) begin
                                r_ack   <= 1'b1;
                                r_state <= c_ST_ACK;
                            end else begin
                                r_state <= c_ST_MEM_RD;
                            end
                        end else begin
                            r_ack   <= 1'b1;
                            r_dat   <= (w_in_reg && !bus.wbs_we_i) ? w_reg_rdata : 32'h0000_0000;
                            r_state <= c_ST_ACK;
                        end
                    end
                end
                c_ST_MEM_RD: begin
                    r_mem_en <= 1'b0;
                    r_abort  <= !bus.wbs_cyc_i;
                    r_state  <= c_ST_MEM_CAP;
                end
                c_ST_MEM_CAP: begin
                    // A master that dropped cyc gets no ack; the read still finished.
                    if (r_abort || !bus.wbs_cyc_i) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_ack   <= 1'b1;
                        r_dat   <= bus.mem_rdata_i;
                        r_state <= c_ST_ACK;
                    end
                end
                c_ST_ACK: begin
                    r_ack    <= 1'b0;
                    r_dat    <= 32'h0000_0000;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_wmask  <= 4'h0;
                    r_state  <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.wbs_ack_o   = r_ack;
    assign bus.wbs_dat_o   = r_dat;
    assign bus.mem_en_o    = r_mem_en;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_wmask_o = r_wmask;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_brqrv_wb_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_brqrv_wb_loader
// Description : Scoreboard bench for brqrv_wb_loader with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brqrv_wb_loader;
    localparam int MEM_AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_done = 1'b0;
    logic core_rst, irq;

    brqrv_wb_loader_if #(.MEM_AW(MEM_AW)) bus ();

    brqrv_wb_loader #(
        .BASE_ADDR  (32'h3000_0000),
        .MEM_OFFSET (32'h0001_0000),
        .MEM_AW     (MEM_AW)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .bus         (bus),
        .core_done_i (core_done),
        .core_rst_o  (core_rst),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Memory seen by the DUT; cleared while reset is held.
    logic [31:0] tb_mem [0:(1<<MEM_AW)-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << MEM_AW); i++) tb_mem[i] <= 32'h0;
        end else if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wmask_o[b]) tb_mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            end else begin
                bus.mem_rdata_i <= tb_mem[bus.mem_addr_o];
            end
        end
    end

    // Reference model: register file and memory contents as plain variables.
    logic        m_hold, m_irq_en, m_done, m_viol, m_bad;
    int          m_wcount;
    logic [31:0] m_scratch;
    logic [31:0] ref_mem [int];

    task automatic model_reset();
        m_hold = 1'b1; m_irq_en = 1'b0; m_done = 1'b0; m_viol = 1'b0; m_bad = 1'b0;
        m_wcount = 0; m_scratch = 32'h0;
        ref_mem.delete();
    endtask

    function automatic logic [31:0] mem_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    typedef struct {
        logic        chk;
        logic [31:0] dat;
    } exp_t;
    exp_t sbq[$];

    task automatic model_access(input logic [31:0] adr, input logic we, input logic [31:0] d,
                                input logic [3:0] sel, output exp_t e, output int lat, output bit ack);
        logic [31:0] off, v;
        int w;
        off = adr - 32'h3000_0000;
        ack = (adr[31:24] == 8'h30);
        e.chk = !we;
        e.dat = 32'h0;
        lat = 1;
        if (!ack) return;
        if (off >= 32'h1_0000 && off < 32'h1_1000) begin
            w = int'((off - 32'h1_0000) >> 2);
            if (!m_hold) m_viol = 1'b1;
            else if (we) begin
                v = mem_rd(w);
                for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = d[8*b +: 8];
                ref_mem[w] = v;
                if (m_wcount < 65535) m_wcount++;
            end else begin
                e.dat = mem_rd(w);
                lat = 3;
            end
        end else if (off < 32'd16) begin
            case (off[3:2])
                2'd0: e.dat = {30'h0, m_irq_en, m_hold};
                2'd1: e.dat = {28'h0, m_bad, m_viol, m_done, !m_hold};
                2'd2: e.dat = 32'(m_wcount);
                default: e.dat = m_scratch;
            endcase
            if (we) begin
                case (off[3:2])
                    2'd0: if (sel[0]) begin m_hold = d[0]; m_irq_en = d[1]; end
                    2'd1: if (sel[0]) begin
                        if (d[1]) m_done = 1'b0;
                        if (d[2]) m_viol = 1'b0;
                        if (d[3]) m_bad  = 1'b0;
                    end
                    2'd2: m_wcount = 0;
                    default: for (int b = 0; b < 4; b++) if (sel[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
                endcase
            end
        end else begin
            m_bad = 1'b1;
        end
    endtask

    // Monitor: every ack pops one expected response.
    always @(negedge clk) begin
        if (bus.wbs_ack_o) begin
            if (sbq.size() == 0) check("spurious_ack", 32'(bus.wbs_ack_o), 32'h0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.chk) check("rdata", bus.wbs_dat_o, e.dat);
            end
        end
        if (bus.mem_en_o) check("mem_owner_hold", 32'(m_hold), 32'h1);
    end

    logic            s_en, s_we;
    logic [3:0]      s_wmask;
    logic [MEM_AW-1:0] s_addr;

    task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] d,
                          input logic [3:0] sel, input bit pulse);
        exp_t e;
        int   exp_lat, lat, acks;
        bit   exp_ack, got;
        model_access(adr, we, d, sel, e, exp_lat, exp_ack);
        if (pulse) m_done = 1'b1;
        if (exp_ack) sbq.push_back(e);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr; bus.wbs_dat_i = d; bus.wbs_sel_i = sel;
        core_done = pulse;
        lat = 0; got = 1'b0; acks = 0;
        if (!exp_ack) begin
            repeat (10) begin
                @(posedge clk); #1 core_done = 1'b0;
                @(negedge clk); if (bus.wbs_ack_o) acks++;
            end
            check("nonhit_no_ack", 32'(acks), 32'h0);
        end else begin
            while (!got && lat < 20) begin
                @(posedge clk); #1 core_done = 1'b0;
                lat++;
                @(negedge clk);
                if (bus.wbs_ack_o) begin
                    got = 1'b1;
                    s_en = bus.mem_en_o; s_we = bus.mem_we_o;
                    s_wmask = bus.mem_wmask_o; s_addr = bus.mem_addr_o;
                end
            end
            check("ack_latency", 32'(got ? lat : 99), 32'(exp_lat));
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic check_side();
        repeat (3) @(negedge clk);
        check("core_rst", 32'(core_rst), 32'(m_hold));
        check("irq", 32'(irq), 32'(m_done & m_irq_en));
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  sel;
        int          k, w, acks;

        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("rst_dat", bus.wbs_dat_o, 32'h0);
        check("rst_mem_en", {28'h0, bus.mem_en_o, bus.mem_we_o, 2'b00} | 32'(bus.mem_wmask_o), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr_o), 32'h0);
        check("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        check("rst_core_rst", 32'(core_rst), 32'h1);
        check("rst_irq", 32'(irq), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        access(32'h3000_0000, 1'b0, 32'h0, 4'hF, 1'b0);
        check_side();

        access(32'h3001_0010, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0);
        check("wr_port", {26'h0, s_en, s_we, s_wmask}, {26'h0, 1'b1, 1'b1, 4'hF});
        check("wr_addr", 32'(s_addr), 32'd4);
        access(32'h3001_0010, 1'b0, 32'h0, 4'hF, 1'b0);
        access(32'h3000_0008, 1'b0, 32'h0, 4'hF, 1'b0);

        for (int i = 0; i < 150; i++) begin
            k   = $urandom_range(0, 9);
            w   = $urandom_range(0, 15);
            sel = 4'($urandom_range(1, 15));
            d   = $urandom;
            case (k)
                0, 1, 2: access(32'h3001_0000 + 32'(w << 2), 1'b1, d, sel, 1'b0);
                3, 4, 5: access(32'h3001_0000 + 32'(w << 2), 1'b0, 32'h0, 4'hF, 1'b0);
                6:       access(32'h3000_000C, 1'b1, d, sel, 1'b0);
                7:       access(32'h3000_0004 + 32'((w & 2) << 2), 1'b0, 32'h0, 4'hF, 1'b0);
                8:       access(32'h3000_0040 + 32'(w << 4), 1'b0, 32'h0, 4'hF, 1'b0);
                default: access(32'h3000_0004, 1'b1, d, 4'hF, 1'b0);
            endcase
        end
        access(32'h3000_000C, 1'b0, 32'h0, 4'hF, 1'b0);
        access(32'h3000_0008, 1'b1, 32'h0, 4'hF, 1'b0);
        access(32'h3000_0004, 1'b1, 32'hF, 4'hF, 1'b0);

        access(32'h3000_0000, 1'b1, 32'h2, 4'hF, 1'b0);
        check_side();
        @(posedge clk); #1 core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
        m_done = 1'b1;
        @(negedge clk);
        check("irq_lag", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        access(32'h3000_0004, 1'b0, 32'h0, 4'hF, 1'b0);
        access(32'h3000_0004, 1'b1, 32'h2, 4'hF, 1'b0);
        check_side();

        access(32'h3001_0020, 1'b1, 32'h1234_5678, 4'hF, 1'b0);
        check("viol_mem_en", 32'(s_en), 32'h0);
        access(32'h3000_0004, 1'b0, 32'h0, 4'hF, 1'b0);
        access(32'h3000_0008, 1'b0, 32'h0, 4'hF, 1'b0);
        access(32'h3001_0010, 1'b0, 32'h0, 4'hF, 1'b0);

        access(32'h3000_0040, 1'b0, 32'h0, 4'hF, 1'b0);
        access(32'h3000_0004, 1'b0, 32'h0, 4'hF, 1'b0);
        access(32'h2000_0000, 1'b0, 32'h0, 4'hF, 1'b0);

        access(32'h3000_0004, 1'b1, 32'h2, 4'hF, 1'b1);
        access(32'h3000_0004, 1'b0, 32'h0, 4'hF, 1'b0);

        access(32'h3000_0000, 1'b1, 32'h1, 4'hF, 1'b0);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = 32'h3001_0010; bus.wbs_sel_i = 4'hF;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("mem_rd_strobe", 32'(bus.mem_en_o), 32'h1);
        acks = 0;
        @(negedge clk);
        check("rst_mem_en_after", 32'(bus.mem_en_o), 32'h0);
        check("rst_core_rst_after", 32'(core_rst), 32'h1);
        repeat (2) begin @(negedge clk); if (bus.wbs_ack_o) acks++; end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) begin @(negedge clk); if (bus.wbs_ack_o) acks++; end
        check("abandon_no_ack", 32'(acks), 32'h0);
        access(32'h3000_0000, 1'b0, 32'h0, 4'hF, 1'b0);
        access(32'h3000_0008, 1'b0, 32'h0, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
